// File: rtl/fifo_queue_ram_pkg.sv
// Shared helpers for the RAM-backed FIFO: pointer/count widths and the
// explicit pointer wrap that lets DEPTH be any value, not only a power of two.
package fifo_queue_ram_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Wraps to 0 after depth-1 instead of relying on natural binary overflow.
  function automatic int wrap_inc(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fifo_queue_ram_if.sv
// Enqueue/dequeue handshakes plus occupancy status of the FIFO.
import fifo_queue_ram_pkg::*;

interface fifo_queue_ram_if #(
  parameter int DATA_W = 16000,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_data;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_data;
  logic [CNT_W-1:0]  count;
  logic              almost_full;

  modport slave (
    input  enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data, count, almost_full
  );

  modport master (
    output enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data, count, almost_full
  );
endinterface

// File: rtl/fifo_ram_1r1w.sv
// 1R1W RAM; the read address is registered and only moves on R0_en, so the
// read data holds steady between reads.
import fifo_queue_ram_pkg::*;

module fifo_ram_1r1w #(
  parameter int DATA_W = 16000,
  parameter int DEPTH  = 16,
  localparam int AW    = ptr_w(DEPTH)
) (
  input  logic              W0_clk,
  input  logic [AW-1:0]     W0_addr,
  input  logic              W0_en,
  input  logic [DATA_W-1:0] W0_data,
  input  logic              R0_clk,
  input  logic [AW-1:0]     R0_addr,
  input  logic              R0_en,
  output logic [DATA_W-1:0] R0_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_addr_q;

  always_ff @(posedge W0_clk)
    if (W0_en) mem[W0_addr] <= W0_data;

  always_ff @(posedge R0_clk)
    if (R0_en) rd_addr_q <= R0_addr;

  assign R0_data = mem[rd_addr_q];
endmodule

// File: rtl/fifo_queue_ram.sv
// Single-clock valid/ready FIFO over a 1R1W RAM. The head entry sits in the
// RAM's read register, so count includes it and deq_valid never depends on deq_ready.
import fifo_queue_ram_pkg::*;

module fifo_queue_ram #(
  parameter int DATA_W    = 16000,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2
) (
  input logic             clock,
  input logic             reset,
  input logic             flush,
  fifo_queue_ram_if.slave io
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  unread, count_q, count_nxt;
  logic              head_valid, af_q;
  logic              clr, enq_fire, deq_fire, rd_en;
  logic [DATA_W-1:0] ram_q;

  assign clr       = reset | flush;
  assign enq_fire  = io.enq_valid && io.enq_ready;
  assign deq_fire  = head_valid && io.deq_ready;
  // Refill the head whenever it is empty or leaving this cycle.
  assign rd_en     = (unread != '0) && (!head_valid || deq_fire);
  assign count_nxt = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);

  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      unread     <= '0;
      count_q    <= '0;
      head_valid <= 1'b0;
      af_q       <= 1'b0;
    end else begin
      if (enq_fire) wr_ptr <= PTR_W'(wrap_inc(int'(wr_ptr), DEPTH));
      if (rd_en)    rd_ptr <= PTR_W'(wrap_inc(int'(rd_ptr), DEPTH));
      if (rd_en)         head_valid <= 1'b1;
      else if (deq_fire) head_valid <= 1'b0;
      unread  <= unread + CNT_W'(enq_fire) - CNT_W'(rd_en);
      count_q <= count_nxt;
      af_q    <= (count_nxt >= CNT_W'(AF_THRESH));
    end
  end

  fifo_ram_1r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .W0_clk  (clock),
    .W0_addr (wr_ptr),
    .W0_en   (enq_fire && !clr),
    .W0_data (io.enq_data),
    .R0_clk  (clock),
    .R0_addr (rd_ptr),
    .R0_en   (rd_en && !clr),
    .R0_data (ram_q)
  );

  // Full means full: a same-cycle dequeue only frees the slot next cycle.
  assign io.enq_ready   = !reset && (count_q < CNT_W'(DEPTH));
  assign io.deq_valid   = head_valid;
  assign io.count       = count_q;
  assign io.almost_full = af_q;
`ifdef RANDOMIZE_GARBAGE_ASSIGN
  assign io.deq_data = head_valid ? ram_q : DATA_W'({((DATA_W + 31) / 32){$urandom}});
`else
  assign io.deq_data = ram_q;
`endif
endmodule

// File: tb/tb_fifo_queue_ram.sv
// Scoreboard bench: a queue model tracks accepted entries, a negedge monitor
// compares every dequeue and the status outputs against it.
module tb_fifo_queue_ram;
  localparam int DW = 32, DEPTH = 5, AF = 4;

  logic clock = 1'b0, reset = 1'b1, flush = 1'b0;
  always #5 clock = ~clock;

  fifo_queue_ram_if #(.DATA_W(DW), .DEPTH(DEPTH)) io ();
  fifo_queue_ram #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clock(clock), .reset(reset), .flush(flush), .io(io)
  );

  int checks = 0, failures = 0, deq_cnt = 0;
  logic [DW-1:0] mq[$];
  bit mon_en = 0, prev_stall = 0;
  logic [DW-1:0] prev_data, exp_d;
  int sz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Monitor: all comparisons against the queue model happen here.
  always @(negedge clock) begin
    if (reset) begin
      mq.delete();
      prev_stall = 0;
    end else if (mon_en) begin
      sz = mq.size();
      chk("count", io.count, sz);
      chk("almost_full", io.almost_full, sz >= AF);
      chk("enq_ready", io.enq_ready, sz < DEPTH);
      if (sz == 0) chk("deq_valid_empty", io.deq_valid, 1'b0);
      if (prev_stall) begin
        chk("stall_valid", io.deq_valid, 1'b1);
        chk("stall_data", io.deq_data, prev_data);
      end
      if (io.deq_valid && io.deq_ready) begin
        deq_cnt++;
        if (sz > 0) begin
          exp_d = mq.pop_front();
          chk("deq_data", io.deq_data, exp_d);
        end
      end
      prev_stall = io.deq_valid && !io.deq_ready && !flush;
      prev_data  = io.deq_data;
      if (flush) mq.delete();
      else if (io.enq_valid && io.enq_ready) mq.push_back(io.enq_data);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic enq_one(input logic [31:0] d);
    bit ok = 0;
    io.enq_valid = 1'b1;
    io.enq_data  = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (io.enq_ready) begin ok = 1; break; end
    end
    if (!ok) bad("enq_timeout");
    cyc();
    io.enq_valid = 1'b0;
  endtask

  task automatic wait_valid(output logic [31:0] d);
    bit ok = 0;
    d = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (io.deq_valid) begin ok = 1; d = io.deq_data; end
      cyc();
      if (ok) break;
    end
    if (!ok) bad("valid_timeout");
  endtask

  task automatic drain();
    bit ok = 0;
    io.deq_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (io.count == 0 && !io.deq_valid) begin ok = 1; break; end
    end
    if (!ok) bad("drain_timeout");
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int s;
    io.enq_valid = 1'b0;
    io.enq_data  = '0;
    io.deq_ready = 1'b0;

    repeat (3) begin
      @(negedge clock);
      chk("rst_enq_ready", io.enq_ready, 1'b0);
      chk("rst_deq_valid", io.deq_valid, 1'b0);
      chk("rst_count", io.count, 0);
    end
    cyc();
    reset  = 1'b0;
    mon_en = 1;
    repeat (10) begin
      @(negedge clock);
      chk("idle_enq_ready", io.enq_ready, 1'b1);
      chk("idle_deq_valid", io.deq_valid, 1'b0);
      chk("idle_count", io.count, 0);
    end
    cyc();

    // Latency: enqueue into empty queue shows at t+2, count back to 0 at t+3.
    io.deq_ready = 1'b1;
    io.enq_valid = 1'b1;
    io.enq_data  = 32'hA0;
    @(negedge clock);
    chk("lat_t_ready", io.enq_ready, 1'b1);
    chk("lat_t_valid", io.deq_valid, 1'b0);
    cyc();
    io.enq_valid = 1'b0;
    @(negedge clock);
    chk("lat_t1_valid", io.deq_valid, 1'b0);
    cyc();
    @(negedge clock);
    chk("lat_t2_valid", io.deq_valid, 1'b1);
    chk("lat_t2_data", io.deq_data, 32'hA0);
    cyc();
    @(negedge clock);
    chk("lat_t3_count", io.count, 0);
    chk("lat_t3_valid", io.deq_valid, 1'b0);
    cyc();

    // Fill to full, then a held sixth offer.
    io.deq_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      enq_one(i);
      @(negedge clock);
      chk("fill_count", io.count, i);
      chk("fill_af", io.almost_full, i >= 4);
      cyc();
    end
    io.enq_valid = 1'b1;
    io.enq_data  = 32'h6;
    repeat (3) begin
      @(negedge clock);
      chk("full_enq_ready", io.enq_ready, 1'b0);
    end
    cyc();
    io.deq_ready = 1'b1;
    @(negedge clock);
    chk("full_deq_ready_same", io.enq_ready, 1'b0);
    chk("full_head", io.deq_data, 32'h1);
    cyc();
    io.deq_ready = 1'b0;
    @(negedge clock);
    chk("held_accept", io.enq_ready, 1'b1);
    cyc();
    io.enq_valid = 1'b0;
    drain();

    // Streaming: 40 enqueues, one dequeue per cycle after two cycles of fill.
    s = deq_cnt;
    io.deq_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      io.enq_valid = 1'b1;
      io.enq_data  = 32'h1000 + i;
      @(negedge clock);
      cyc();
    end
    io.enq_valid = 1'b0;
    chk("stream_deqs", deq_cnt - s, 38);
    drain();

    // Hold: head 0x33 stays put under back-pressure while others land.
    io.deq_ready = 1'b0;
    enq_one(32'h33);
    wait_valid(d);
    chk("hold_first", d, 32'h33);
    for (int i = 0; i < 6; i++) begin
      io.enq_valid = (i < 3);
      io.enq_data  = 32'h100 + i;
      @(negedge clock);
      chk("hold_valid", io.deq_valid, 1'b1);
      chk("hold_data", io.deq_data, 32'h33);
      cyc();
    end
    io.enq_valid = 1'b0;
    @(negedge clock);
    chk("hold_count", io.count, 4);
    cyc();
    drain();

    // Flush with count=3 and simultaneous enq/deq fires.
    io.deq_ready = 1'b0;
    enq_one(32'h51);
    enq_one(32'h52);
    enq_one(32'h53);
    @(negedge clock);
    chk("pre_flush_count", io.count, 3);
    cyc();
    flush = 1'b1;
    io.enq_valid = 1'b1;
    io.enq_data  = 32'hEE;
    io.deq_ready = 1'b1;
    @(negedge clock);
    chk("flush_enq_ready", io.enq_ready, 1'b1);
    chk("flush_deq_valid", io.deq_valid, 1'b1);
    cyc();
    flush = 1'b0;
    io.enq_valid = 1'b0;
    io.deq_ready = 1'b0;
    @(negedge clock);
    chk("post_flush_count", io.count, 0);
    chk("post_flush_valid", io.deq_valid, 1'b0);
    cyc();
    enq_one(32'h77);
    io.deq_ready = 1'b1;
    wait_valid(d);
    chk("flush_new_data", d, 32'h77);
    drain();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      io.enq_valid = ($urandom_range(0, 3) != 0);
      io.enq_data  = $urandom;
      io.deq_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 39) == 0);
      @(negedge clock);
      cyc();
    end
    io.enq_valid = 1'b0;
    flush = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
